// File: rtl/alpu_operand_sequencer_if.sv
// Operand-set handoff between the operand sequencer and the ALPU stage.
//   a_o, b_o     captured operands (REG_WIDTH)
//   instr_o      captured opcode (INSTR_WIDTH)
//   cin_o        captured carry-in
//   valid_o      operand set complete and held
//   ready_i      ALPU stage accepts the operand set this cycle
//   state_o      sequencer state for LED display
// master: sequencer side (drives the operand set), slave: ALPU side (drives ready_i).
interface alpu_operand_sequencer_if #(
  parameter int REG_WIDTH   = 4,
  parameter int INSTR_WIDTH = 4
);
  logic [REG_WIDTH-1:0]   a_o;
  logic [REG_WIDTH-1:0]   b_o;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic                   cin_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [1:0]             state_o;

  modport master (
    output a_o, b_o, instr_o, cin_o, valid_o, state_o,
    input  ready_i
  );

  modport slave (
    input  a_o, b_o, instr_o, cin_o, valid_o, state_o,
    output ready_i
  );
endinterface

// File: rtl/alpu_operand_sequencer.sv
// Operand-entry stage for the ALPU board harness.
// Synchronises and debounces the raw buttons, turns advance/clear presses into
// single-cycle pulses, and walks A -> B -> OP -> ISSUE capturing the switches
// once per press. The completed set is held with valid_o until the ALPU stage
// takes it with ready_i.
//   clk      system clock
//   reset_n  asynchronous active-low reset (deassertion expected synchronous to clk)
//   sw_i     raw switches: operand / opcode source
//   btn_i    raw buttons: [0] advance, [1] clear, [2] carry-in level, [3] unused
//   bus      operand set, valid/ready handshake and state display (master side)
module alpu_operand_sequencer #(
  parameter int REG_WIDTH       = 4,
  parameter int INSTR_WIDTH     = 4,
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REG_WIDTH-1:0] sw_i,
  input  logic [3:0]           btn_i,
  alpu_operand_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value on the last differing cycle before the new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A     = 2'b00,
    S_B     = 2'b01,
    S_OP    = 2'b10,
    S_ISSUE = 2'b11
  } state_t;

  // Two-flop synchronisers; btn_i[3] has no function and is not brought in.
  logic [REG_WIDTH-1:0] sw_meta, sw_sync;
  logic [2:0]           btn_meta, btn_sync;

  logic [2:0]           db_level;
  logic [CNT_W-1:0]     db_cnt [3];
  logic [1:0]           level_d;
  logic [1:0]           press;     // [0] advance pulse, [1] clear pulse

  state_t                 state_q, state_d;
  logic [REG_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   cin_q, cin_d;
  logic                   valid_q, valid_d;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update together from pre-edge values; the two sync stages depend on it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= sw_i;
      sw_sync  <= sw_meta;
      btn_meta <= btn_i[2:0];
      btn_sync <= btn_meta;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing
  // cycles; any cycle that agrees restarts the count, so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_level <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (btn_sync[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_level[i] <= btn_sync[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising-edge pulses of the debounced advance/clear levels, one cycle wide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_d <= '0;
      press   <= '0;
    end else begin
      level_d <= db_level[1:0];
      press   <= db_level[1:0] & ~level_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      instr_q <= '0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      instr_q <= instr_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: every signal gets its hold value first so no path through the
  // case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    instr_d = instr_q;
    cin_d   = cin_q;

    if (press[1]) begin
      // Clear outranks both advance and a same-cycle handshake.
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      instr_d = '0;
      cin_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_A: if (press[0]) begin
          a_d     = sw_sync;
          state_d = S_B;
        end
        S_B: if (press[0]) begin
          b_d     = sw_sync;
          state_d = S_OP;
        end
        S_OP: if (press[0]) begin
          instr_d = sw_sync[INSTR_WIDTH-1:0];
          cin_d   = db_level[2];
          state_d = S_ISSUE;
        end
        S_ISSUE: if (valid_q && bus.ready_i) begin
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end

    // Registered valid tracks the state being entered, so it is high exactly
    // while state_q is S_ISSUE.
    valid_d = (state_d == S_ISSUE);
  end

  assign bus.a_o     = a_q;
  assign bus.b_o     = b_q;
  assign bus.instr_o = instr_q;
  assign bus.cin_o   = cin_q;
  assign bus.valid_o = valid_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_alpu_operand_sequencer.sv
// Directed bench for alpu_operand_sequencer with DEBOUNCE_CYCLES=4, REG_WIDTH=4.
// Inputs change 1 time unit after a rising edge; outputs are checked on the
// falling edge. A press raised for 10 cycles yields its capture 8 edges later.
module tb_alpu_operand_sequencer;

  localparam int RW = 4;
  localparam int IW = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [RW-1:0] sw;
  logic [3:0]    btn;

  int n_checks = 0;
  int n_errors = 0;

  alpu_operand_sequencer_if #(.REG_WIDTH(RW), .INSTR_WIDTH(IW)) bus ();

  alpu_operand_sequencer #(
    .REG_WIDTH      (RW),
    .INSTR_WIDTH    (IW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sw_i   (sw),
    .btn_i  (btn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then step just past the last one to drive inputs.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise the given buttons long enough to pass debounce, then release fully.
  task automatic press(input logic [3:0] mask);
    btn = btn | mask;
    edges(10);
    btn = btn & ~mask;
    edges(10);
  endtask

  task automatic check_all(input string tag, input logic [RW-1:0] a,
                           input logic [RW-1:0] b, input logic [IW-1:0] instr,
                           input logic cin, input logic valid, input logic [1:0] st);
    check({tag, ".a"},     bus.a_o,     a);
    check({tag, ".b"},     bus.b_o,     b);
    check({tag, ".instr"}, bus.instr_o, instr);
    check({tag, ".cin"},   bus.cin_o,   cin);
    check({tag, ".valid"}, bus.valid_o, valid);
    check({tag, ".state"}, bus.state_o, st);
  endtask

  initial begin
    // 1. Reset with everything high; hold outputs at 0 after release.
    reset_n     = 1'b0;
    sw          = 4'hF;
    btn         = 4'hF;
    bus.ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    reset_n = 1'b1;
    // Buttons still high: advance and clear pulse together, clear wins.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_reset.state", bus.state_o, 2'b00);
      check("post_reset.valid", bus.valid_o, 1'b0);
    end
    check_all("post_reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    edges(1);
    btn = 4'h0;
    edges(12);

    // 2. Three-cycle glitch on advance must not pass debounce.
    btn[0] = 1'b1;
    edges(3);
    btn[0] = 1'b0;
    edges(15);
    @(negedge clk);
    check("glitch.state", bus.state_o, 2'b00);
    check("glitch.a",     bus.a_o,     4'h0);

    // 3. Full entry and handshake.
    edges(1);
    sw = 4'h3;
    press(4'b0001);
    @(negedge clk);
    check("capA.state", bus.state_o, 2'b01);
    check("capA.a",     bus.a_o,     4'h3);
    edges(1);
    sw = 4'h5;
    press(4'b0001);
    @(negedge clk);
    check("capB.state", bus.state_o, 2'b10);
    check("capB.b",     bus.b_o,     4'h5);
    edges(1);
    sw     = 4'h4;
    btn[2] = 1'b1;
    edges(10);
    press(4'b0001);
    @(negedge clk);
    check_all("issue", 4'h3, 4'h5, 4'h4, 1'b1, 1'b1, 2'b11);
    edges(1);
    sw = 4'hA;  // switches ignored outside an advance
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("issue_hold.valid", bus.valid_o, 1'b1);
      check("issue_hold.a",     bus.a_o,     4'h3);
    end
    edges(1);
    bus.ready_i = 1'b1;
    edges(1);
    bus.ready_i = 1'b0;
    @(negedge clk);
    check_all("handshake", 4'h3, 4'h5, 4'h4, 1'b1, 1'b0, 2'b00);

    // ready_i with nothing valid changes nothing.
    edges(1);
    bus.ready_i = 1'b1;
    edges(5);
    bus.ready_i = 1'b0;
    @(negedge clk);
    check_all("idle_ready", 4'h3, 4'h5, 4'h4, 1'b1, 1'b0, 2'b00);

    // 4. Holding advance for 50 cycles steps exactly once.
    edges(1);
    sw     = 4'h9;
    btn[0] = 1'b1;
    edges(50);
    @(negedge clk);
    check("hold.state", bus.state_o, 2'b01);
    check("hold.a",     bus.a_o,     4'h9);
    edges(1);
    btn[0] = 1'b0;
    edges(12);
    @(negedge clk);
    check("hold_release.state", bus.state_o, 2'b01);

    // 5. Advance + clear together in S_OP: clear wins, fields zeroed.
    edges(1);
    sw = 4'h6;
    press(4'b0001);
    @(negedge clk);
    check("toOP.state", bus.state_o, 2'b10);
    check("toOP.b",     bus.b_o,     4'h6);
    edges(1);
    press(4'b0011);
    @(negedge clk);
    check_all("clear", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);

    // 6. Asynchronous reset while issuing.
    edges(1);
    sw = 4'h1;
    press(4'b0001);
    sw = 4'h2;
    press(4'b0001);
    sw = 4'h7;
    press(4'b0001);
    @(negedge clk);
    check_all("issue2", 4'h1, 4'h2, 4'h7, 1'b1, 1'b1, 2'b11);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    btn     = 4'h0;
    edges(5);
    @(negedge clk);
    check_all("after_reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

endmodule
